// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths and control-bundle bit positions for the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;
    localparam int XLEN          = 64;
    localparam int CTRL_W        = 8;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;
endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard compare between decode and EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hazard
);
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = id_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with WB bypass, load-use bubble,
//               flush handling and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import riscv_pkg::CTRL_W;
    import riscv_pkg::CTRL_MEMREAD;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_read_data1,
    input  logic [XLEN-1:0]   id_read_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_read_data1,
    output logic [XLEN-1:0]   ex_read_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            w_hazard;
    logic            w_byp1;
    logic            w_byp2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    load_use_detect u_load_use_detect (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl[CTRL_MEMREAD]),
        .ex_rd      (ex_rd),
        .hazard     (w_hazard)
    );

    // A wrong-path instruction under flush must not freeze fetch.
    assign stall_out = w_hazard && !flush;

    assign w_byp1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    assign w_byp2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    assign w_op1  = w_byp1 ? wb_data : id_read_data1;
    assign w_op2  = w_byp2 ? wb_data : id_read_data2;

    always_ff @(posedge clk) begin
        if (reset || flush || w_hazard) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_ctrl       <= '0;
        end else begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_read_data1 <= w_op1;
            ex_read_data2 <= w_op2;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_ctrl       <= id_ctrl;
        end
    end

    // Flush takes priority: a flushed hazard is counted as a flush only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            if (id_valid && (flush_count != c_CNT_MAX))
                flush_count <= flush_count + c_CNT_ONE;
        end else if (w_hazard) begin
            if (stall_count != c_CNT_MAX)
                stall_count <= stall_count + c_CNT_ONE;
        end
    end
endmodule

`default_nettype wire
